// File: rtl/seq_divider.sv
// Multicycle restoring divider, one quotient bit per cycle, with start/busy/ready
// handshake, optional two's-complement operation and div-by-zero/overflow flags.
module seq_divider #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_0,
    output logic             overflow,
    output logic             busy,
    output logic             result_rdy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_0_q, div_by_0_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             result_rdy_q, result_rdy_d;

    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign quotient   = quotient_q;
    assign remainder  = remainder_q;
    assign div_by_0   = div_by_0_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
    assign result_rdy = result_rdy_q;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvsr_d       = dvsr_q;
        cnt_d        = cnt_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        div_by_0_d   = div_by_0_q;
        overflow_d   = overflow_q;
        busy_d       = 1'b0;
        result_rdy_d = 1'b0;

        sgn   = SIGNED_EN && is_signed;
        a_mag = (sgn && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
        b_mag = (sgn && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

        // Widened trial subtract: the shifted-in bit can push rem past WIDTH bits
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvsr_q};
        step_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        case (state_q)
            S_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    quotient_d   = neg_quo_q ? (~step_quo + WIDTH'(1)) : step_quo;
                    remainder_d  = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;
                    result_rdy_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (ctrl_DIV) begin
                    div_by_0_d = 1'b0;
                    overflow_d = 1'b0;
                    if (divisor == '0) begin
                        quotient_d   = '1;
                        remainder_d  = dividend;
                        div_by_0_d   = 1'b1;
                        result_rdy_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (sgn && dividend == MIN_VAL && divisor == '1) begin
                        quotient_d   = MIN_VAL;
                        remainder_d  = '0;
                        overflow_d   = 1'b1;
                        result_rdy_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvsr_d    = b_mag;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        neg_quo_d = sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = sgn && dividend[WIDTH-1];
                        busy_d    = 1'b1;
                        state_d   = S_BUSY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            cnt_q        <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            div_by_0_q   <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            result_rdy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvsr_q       <= dvsr_d;
            cnt_q        <= cnt_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            div_by_0_q   <= div_by_0_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            result_rdy_q <= result_rdy_d;
        end
    end

endmodule
